rv32v_mem_port_arbiter: RTL and testbench

// - Round-robin arbiter sharing the single vector memory port between NUM_REQ requesters
//   (req 0 = vector load unit, req 1 = vector store unit).
// - Latches the winner's request, holds it on the port until memory finishes, then returns the result.
// - Drives busy_mem into the vector hazard unit, which stalls the mem stage and upstream stages.

---
 rtl/rv32v_mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_rv32v_mem_port_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32v_mem_port_arbiter.sv
// Round-robin arbiter sharing the vector memory port between NUM_REQ requesters.
// Define RV32V_ARB_BACK2BACK_EN to re-arbitrate in the completion cycle (no IDLE bubble).
module rv32v_mem_port_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            req_wen_i,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata_i,
  input  logic [NUM_REQ*(DATA_W/8)-1:0] req_byte_en_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            done_o,
  output logic [DATA_W-1:0]             rdata_o,
  output logic                          mem_ren_o,
  output logic                          mem_wen_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic [DATA_W-1:0]             mem_wdata_o,
  output logic [DATA_W/8-1:0]           mem_byte_en_o,
  input  logic                          mem_busy_i,
  input  logic [DATA_W-1:0]             mem_rdata_i,
  output logic                          busy_mem_o
);

  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e              state_q;
  logic [PTR_W-1:0]    owner_q;
  logic [PTR_W-1:0]    last_owner_q;
  logic                wen_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;
  logic                flushed_q;

  logic                completing;
  logic                done_valid;
  logic [NUM_REQ-1:0]  arb_req;
  logic [PTR_W-1:0]    arb_idx;
  logic [PTR_W-1:0]    win;
  logic                arb_fire;
  logic                sel_wen;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [BE_W-1:0]     sel_be;

  assign completing = (state_q == ST_BUSY) && !mem_busy_i;
  assign done_valid = completing && !flushed_q;

  // Requests eligible for arbitration this cycle (the finishing owner is excluded on back-to-back)
  always_comb begin
    arb_req = '0;
    if (rst_n && !flush_i) begin
      if (state_q == ST_IDLE) begin
        arb_req = req_i;
      end
`ifdef RV32V_ARB_BACK2BACK_EN
      else if (completing) begin
        arb_req = req_i;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (owner_q == PTR_W'(i)) arb_req[i] = 1'b0;
        end
      end
`endif
    end
  end

  // Round-robin scan from last_owner+1; wrap by compare so non-power-of-2 counts stay in range
  always_comb begin
    arb_fire = 1'b0;
    win      = '0;
    arb_idx  = last_owner_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      arb_idx = (arb_idx == LAST_IDX) ? '0 : arb_idx + PTR_W'(1);
      if (!arb_fire && arb_req[arb_idx]) begin
        arb_fire = 1'b1;
        win      = arb_idx;
      end
    end
  end

  always_comb begin
    sel_wen   = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    gnt_o     = '0;
    done_o    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == PTR_W'(i)) begin
        sel_wen   = req_wen_i[i];
        sel_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata_i[i*DATA_W +: DATA_W];
        sel_be    = req_byte_en_i[i*BE_W +: BE_W];
      end
      gnt_o[i]  = arb_fire && (win == PTR_W'(i));
      done_o[i] = done_valid && (owner_q == PTR_W'(i));
    end
  end

  assign rdata_o       = done_valid ? mem_rdata_i : '0;
  assign mem_ren_o     = (state_q == ST_BUSY) && !wen_q;
  assign mem_wen_o     = (state_q == ST_BUSY) && wen_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign mem_byte_en_o = be_q;

  always_comb begin
    busy_mem_o = 1'b0;
    if (!rst_n) begin
      busy_mem_o = 1'b0;
    end else if (state_q == ST_IDLE) begin
      busy_mem_o = |req_i;
    end else begin
      busy_mem_o = !done_valid || arb_fire;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= LAST_IDX;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      flushed_q    <= 1'b0;
    end else begin
      if (arb_fire) begin
        owner_q      <= win;
        last_owner_q <= win;
        wen_q        <= sel_wen;
        addr_q       <= sel_addr;
        wdata_q      <= sel_wdata;
        be_q         <= sel_be;
      end
      case (state_q)
        ST_IDLE: begin
          if (arb_fire) state_q <= ST_BUSY;
        end
        ST_BUSY: begin
          if (completing) begin
            flushed_q <= 1'b0;
            state_q   <= arb_fire ? ST_BUSY : ST_IDLE;
          end else if (flush_i) begin
            // In-flight access is never aborted; only its completion pulse is dropped
            flushed_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32v_mem_port_arbiter.sv
// Directed self-checking bench for rv32v_mem_port_arbiter (default build, two requesters).
module tb_rv32v_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [1:0]  req;
  logic [1:0]  req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_byte_en;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [31:0] rdata;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic        mem_busy;
  logic [31:0] mem_rdata;
  logic        busy_mem;

  int tests_run    = 0;
  int tests_failed = 0;

  rv32v_mem_port_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush),
    .req_i         (req),
    .req_wen_i     (req_wen),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .req_byte_en_i (req_byte_en),
    .gnt_o         (gnt),
    .done_o        (done),
    .rdata_o       (rdata),
    .mem_ren_o     (mem_ren),
    .mem_wen_o     (mem_wen),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_byte_en_o (mem_byte_en),
    .mem_busy_i    (mem_busy),
    .mem_rdata_i   (mem_rdata),
    .busy_mem_o    (busy_mem)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; req = 2'b11; req_wen = 2'b00;
    req_addr = 64'h0000_0200_0000_0100; req_wdata = '0; req_byte_en = '0;
    mem_busy = 1'b1; mem_rdata = 32'hA5A5_A5A5;
    tick(); tick();
    @(negedge clk);
    tests_run++;
    if ({gnt, done, mem_ren, mem_wen, busy_mem} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got gnt=%b done=%b ren=%b wen=%b busy=%b expected all 0",
               gnt, done, mem_ren, mem_wen, busy_mem);
    end
    tests_run++;
    if ({mem_addr, mem_wdata, mem_byte_en, rdata} !== 100'b0) begin
      tests_failed++;
      $display("FAIL reset_data: got addr=%h wdata=%h be=%h rdata=%h expected all 0",
               mem_addr, mem_wdata, mem_byte_en, rdata);
    end
    tick();
    rst_n = 1'b1; req = 2'b00;
    @(negedge clk);
    tests_run++;
    if (busy_mem !== 1'b0 || gnt !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_idle: got busy=%b gnt=%b expected 0 00", busy_mem, gnt);
    end
    tick();
  endtask

  task automatic test_single_load();
    req = 2'b01; req_wen = 2'b00; req_addr = 64'h0000_0000_0000_0100; mem_busy = 1'b1;
    @(negedge clk);
    tests_run++;
    if (gnt !== 2'b01 || mem_ren !== 1'b0 || busy_mem !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_grant: got gnt=%b ren=%b busy=%b expected 01 0 1", gnt, mem_ren, busy_mem);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      mem_busy  = (k == 2) ? 1'b0 : 1'b1;
      mem_rdata = 32'h1234_5678;
      @(negedge clk);
      tests_run++;
      if (mem_ren !== 1'b1 || mem_wen !== 1'b0 || mem_addr !== 32'h100) begin
        tests_failed++;
        $display("FAIL load_strobe t%0d: got ren=%b wen=%b addr=%h expected 1 0 00000100",
                 k + 1, mem_ren, mem_wen, mem_addr);
      end
      tests_run++;
      if (done !== ((k == 2) ? 2'b01 : 2'b00)) begin
        tests_failed++;
        $display("FAIL load_done t%0d: got %b expected %b", k + 1, done, (k == 2) ? 2'b01 : 2'b00);
      end
      if (k == 2) begin
        tests_run++;
        if (rdata !== 32'h1234_5678 || busy_mem !== 1'b0) begin
          tests_failed++;
          $display("FAIL load_rdata: got rdata=%h busy=%b expected 12345678 0", rdata, busy_mem);
        end
      end
      tick();
    end
    req = 2'b00; mem_busy = 1'b1;
    @(negedge clk);
    tests_run++;
    if (mem_ren !== 1'b0 || done !== 2'b00 || busy_mem !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_release: got ren=%b done=%b busy=%b expected 0 00 0", mem_ren, done, busy_mem);
    end
    tick();
  endtask

  task automatic test_store();
    req = 2'b10; req_wen = 2'b10; mem_busy = 1'b1; mem_rdata = 32'h0;
    req_addr    = 64'h0000_0300_0000_0111;
    req_wdata   = 64'hDEAD_BEEF_1111_1111;
    req_byte_en = 8'hC3;
    @(negedge clk);
    tests_run++;
    if (gnt !== 2'b10) begin
      tests_failed++;
      $display("FAIL store_grant: got %b expected 10", gnt);
    end
    tick();
    req_wdata = 64'h0; req_byte_en = 8'h0; req_addr = 64'h0;
    @(negedge clk);
    tests_run++;
    if (mem_wen !== 1'b1 || mem_ren !== 1'b0 || mem_addr !== 32'h300) begin
      tests_failed++;
      $display("FAIL store_strobe: got wen=%b ren=%b addr=%h expected 1 0 00000300", mem_wen, mem_ren, mem_addr);
    end
    tests_run++;
    if (mem_wdata !== 32'hDEAD_BEEF || mem_byte_en !== 4'hC || done !== 2'b00) begin
      tests_failed++;
      $display("FAIL store_data: got wdata=%h be=%h done=%b expected deadbeef c 00", mem_wdata, mem_byte_en, done);
    end
    tick();
    mem_busy = 1'b0;
    @(negedge clk);
    tests_run++;
    if (done !== 2'b10 || mem_wdata !== 32'hDEAD_BEEF || mem_byte_en !== 4'hC || mem_wen !== 1'b1) begin
      tests_failed++;
      $display("FAIL store_done: got done=%b wdata=%h be=%h wen=%b expected 10 deadbeef c 1",
               done, mem_wdata, mem_byte_en, mem_wen);
    end
    tick();
    req = 2'b00; req_wen = 2'b00; mem_busy = 1'b1;
    @(negedge clk);
    tests_run++;
    if (mem_wen !== 1'b0) begin
      tests_failed++;
      $display("FAIL store_release: got wen=%b expected 0", mem_wen);
    end
    tick();
  endtask

  task automatic test_contention();
    logic [1:0]  exp_g [4];
    logic [31:0] exp_a [4];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    exp_a[0] = 32'h100; exp_a[1] = 32'h200; exp_a[2] = 32'h100; exp_a[3] = 32'h200;
    rst_n = 1'b0; req = 2'b00;
    tick();
    rst_n = 1'b1;
    req = 2'b11; req_wen = 2'b00; req_addr = 64'h0000_0200_0000_0100; mem_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests_run++;
      if (gnt !== exp_g[k] || mem_ren !== 1'b0) begin
        tests_failed++;
        $display("FAIL contention_grant %0d: got gnt=%b ren=%b expected %b 0", k, gnt, mem_ren, exp_g[k]);
      end
      tick();
      @(negedge clk);
      tests_run++;
      if (done !== exp_g[k] || mem_addr !== exp_a[k] || gnt !== 2'b00) begin
        tests_failed++;
        $display("FAIL contention_done %0d: got done=%b addr=%h gnt=%b expected %b %h 00",
                 k, done, mem_addr, gnt, exp_g[k], exp_a[k]);
      end
      tick();
    end
    req = 2'b00; mem_busy = 1'b1;
    tick();
  endtask

  task automatic test_flush_busy();
    req = 2'b01; req_wen = 2'b00; req_addr = 64'h0000_0000_0000_0400; mem_busy = 1'b1;
    @(negedge clk);
    tests_run++;
    if (gnt !== 2'b01) begin
      tests_failed++;
      $display("FAIL flush_grant: got %b expected 01", gnt);
    end
    tick();
    for (int k = 1; k <= 3; k++) begin
      flush = (k == 2) ? 1'b1 : 1'b0;
      @(negedge clk);
      tests_run++;
      if (mem_ren !== 1'b1 || busy_mem !== 1'b1 || done !== 2'b00) begin
        tests_failed++;
        $display("FAIL flush_hold t%0d: got ren=%b busy=%b done=%b expected 1 1 00", k, mem_ren, busy_mem, done);
      end
      tick();
    end
    flush = 1'b0; mem_busy = 1'b0; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    tests_run++;
    if (done !== 2'b00 || mem_ren !== 1'b1 || busy_mem !== 1'b1 || rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL flush_complete: got done=%b ren=%b busy=%b rdata=%h expected 00 1 1 00000000",
               done, mem_ren, busy_mem, rdata);
    end
    tick();
    mem_busy = 1'b1; flush = 1'b1;
    @(negedge clk);
    tests_run++;
    if (gnt !== 2'b00 || mem_ren !== 1'b0 || busy_mem !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_idle_block: got gnt=%b ren=%b busy=%b expected 00 0 1", gnt, mem_ren, busy_mem);
    end
    tick();
    flush = 1'b0;
    @(negedge clk);
    tests_run++;
    if (gnt !== 2'b01) begin
      tests_failed++;
      $display("FAIL flush_regrant: got %b expected 01", gnt);
    end
    tick();
    mem_busy = 1'b0;
    @(negedge clk);
    tests_run++;
    if (done !== 2'b01 || rdata !== 32'h5555_AAAA) begin
      tests_failed++;
      $display("FAIL flush_cleared: got done=%b rdata=%h expected 01 5555aaaa", done, rdata);
    end
    tick();
    req = 2'b00; mem_busy = 1'b1;
    tick();
  endtask

  task automatic test_reset_busy();
    req = 2'b01; req_wen = 2'b00; req_addr = 64'h0000_0000_0000_0500; mem_busy = 1'b1;
    tick();
    @(negedge clk);
    tests_run++;
    if (mem_ren !== 1'b1 || mem_addr !== 32'h500) begin
      tests_failed++;
      $display("FAIL rstbusy_active: got ren=%b addr=%h expected 1 00000500", mem_ren, mem_addr);
    end
    tick();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({mem_ren, mem_wen, gnt, done, busy_mem} !== 7'b0 || mem_addr !== 32'h0 || rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL rstbusy_release: got ren=%b wen=%b gnt=%b done=%b busy=%b addr=%h rdata=%h expected all 0",
               mem_ren, mem_wen, gnt, done, busy_mem, mem_addr, rdata);
    end
    tick();
    rst_n = 1'b1; req = 2'b11; mem_busy = 1'b0;
    @(negedge clk);
    tests_run++;
    if (gnt !== 2'b01) begin
      tests_failed++;
      $display("FAIL rstbusy_pointer: got gnt=%b expected 01", gnt);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (done !== 2'b01) begin
      tests_failed++;
      $display("FAIL rstbusy_done0: got %b expected 01", done);
    end
    tick();
    req = 2'b10;
    @(negedge clk);
    tests_run++;
    if (gnt !== 2'b10) begin
      tests_failed++;
      $display("FAIL rstbusy_grant1: got %b expected 10", gnt);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (done !== 2'b10) begin
      tests_failed++;
      $display("FAIL rstbusy_done1: got %b expected 10", done);
    end
    tick();
    req = 2'b00; mem_busy = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_store();
    test_contention();
    test_flush_busy();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
